// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared types and helpers for the multi-port SRAM family.
//               - sram_state_t : init engine state (INIT / READY)
//               - clog2        : ceiling log2 for derived widths
//               - sel_w        : width of a write-port selector (min 1 bit)
//               - SRAM_INIT_PTR_PAD : extra init-pointer bit so that a fully
//                 populated array (DEPTH == 2**INDEX) can be walked without
//                 the pointer wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_t;

  // Init pointer width is SRAM_INDEX + SRAM_INIT_PTR_PAD.
  localparam int SRAM_INIT_PTR_PAD = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int sel_w(input int num_ports);
    return (num_ports > 1) ? clog2(num_ports) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_wr_arbiter
// Description : Combinational write-port qualification and matching.
//   addr_rd_i  : packed read addresses
//   addr_wr_i  : packed write addresses
//   we_i       : write enables
//   wr_vld_o   : per write port, enabled and address in range
//   rd_hit_o   : per read port, some valid write targets its address
//   rd_sel_o   : per read port, highest-numbered matching write port
//   conflict_o : two or more valid writes share an address
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wr_arbiter
  import sram_pkg::*;
#(
  parameter int SRAM_DEPTH = 16,
  parameter int SRAM_INDEX = 4,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 4,
  parameter int WSEL_W     = sel_w(NUM_WR)
) (
  input  logic [NUM_RD*SRAM_INDEX-1:0] addr_rd_i,
  input  logic [NUM_WR*SRAM_INDEX-1:0] addr_wr_i,
  input  logic [NUM_WR-1:0]            we_i,
  output logic [NUM_WR-1:0]            wr_vld_o,
  output logic [NUM_RD-1:0]            rd_hit_o,
  output logic [NUM_RD*WSEL_W-1:0]     rd_sel_o,
  output logic                         conflict_o
);

  localparam logic [SRAM_INDEX:0] DEPTH_LIM = (SRAM_INDEX+1)'(SRAM_DEPTH);

  always_comb begin
    wr_vld_o   = '0;
    rd_hit_o   = '0;
    rd_sel_o   = '0;
    conflict_o = 1'b0;

    for (int w = 0; w < NUM_WR; w++) begin
      wr_vld_o[w] = we_i[w] &&
                    ({1'b0, addr_wr_i[w*SRAM_INDEX +: SRAM_INDEX]} < DEPTH_LIM);
    end

    // Ascending scan: a later (higher) port overwrites the selection, so the
    // highest-numbered matching port wins, mirroring the write priority.
    for (int p = 0; p < NUM_RD; p++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_vld_o[w] &&
            (addr_wr_i[w*SRAM_INDEX +: SRAM_INDEX] == addr_rd_i[p*SRAM_INDEX +: SRAM_INDEX])) begin
          rd_hit_o[p]                    = 1'b1;
          rd_sel_o[p*WSEL_W +: WSEL_W]   = WSEL_W'(w);
        end
      end
    end

    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_vld_o[i] && wr_vld_o[j] &&
            (addr_wr_i[i*SRAM_INDEX +: SRAM_INDEX] == addr_wr_i[j*SRAM_INDEX +: SRAM_INDEX])) begin
          conflict_o = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_nrmw_init.sv
`default_nettype none
// ============================================================================
// Module      : sram_nrmw_init
// Description : Parametrised NUM_RD-read / NUM_WR-write SRAM with a
//               sequential initialisation engine, write priority
//               (highest port wins), registered conflict flag and optional
//               read-during-write bypass.
//   clk, reset     : clock, synchronous active-high reset
//   addr_rd_i      : packed read addresses  (port p at [p*SRAM_INDEX +: SRAM_INDEX])
//   data_rd_o      : packed read data       (port p at [p*SRAM_WIDTH +: SRAM_WIDTH])
//   addr_wr_i      : packed write addresses
//   we_i           : write enables
//   data_wr_i      : packed write data
//   ready_o        : initialisation finished, array usable
//   wr_conflict_o  : previous cycle had colliding valid writes
// Revision    : 1.0 - initial release
// ============================================================================
module sram_nrmw_init
  import sram_pkg::*;
#(
  parameter int                    SRAM_DEPTH  = 16,
  parameter int                    SRAM_INDEX  = 4,
  parameter int                    SRAM_WIDTH  = 8,
  parameter int                    NUM_RD      = 4,
  parameter int                    NUM_WR      = 4,
  parameter logic [SRAM_WIDTH-1:0] RESET_VALUE = '0,
  parameter bit                    BYPASS_EN   = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*SRAM_INDEX-1:0] addr_rd_i,
  output logic [NUM_RD*SRAM_WIDTH-1:0] data_rd_o,
  input  logic [NUM_WR*SRAM_INDEX-1:0] addr_wr_i,
  input  logic [NUM_WR-1:0]            we_i,
  input  logic [NUM_WR*SRAM_WIDTH-1:0] data_wr_i,
  output logic                         ready_o,
  output logic                         wr_conflict_o
);

  localparam int SRAM_INIT_PTR_W = SRAM_INDEX + SRAM_INIT_PTR_PAD;
  localparam int WSEL_W          = sel_w(NUM_WR);
  localparam logic [SRAM_INIT_PTR_W-1:0] LAST_PTR  = SRAM_INIT_PTR_W'(SRAM_DEPTH - 1);
  localparam logic [SRAM_INDEX:0]        DEPTH_LIM = (SRAM_INDEX+1)'(SRAM_DEPTH);

  sram_state_t                state_q, state_d;
  logic [SRAM_INIT_PTR_W-1:0] init_ptr_q, init_ptr_d;
  logic                       wr_conflict_q, wr_conflict_d;
  logic [SRAM_WIDTH-1:0]      mem_q [SRAM_DEPTH];
  logic [SRAM_WIDTH-1:0]      mem_d [SRAM_DEPTH];

  logic [NUM_WR-1:0]          wr_vld;
  logic [NUM_RD-1:0]          rd_hit;
  logic [NUM_RD*WSEL_W-1:0]   rd_sel;
  logic                       conflict;

  sram_wr_arbiter #(
    .SRAM_DEPTH (SRAM_DEPTH),
    .SRAM_INDEX (SRAM_INDEX),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR),
    .WSEL_W     (WSEL_W)
  ) u_arb (
    .addr_rd_i  (addr_rd_i),
    .addr_wr_i  (addr_wr_i),
    .we_i       (we_i),
    .wr_vld_o   (wr_vld),
    .rd_hit_o   (rd_hit),
    .rd_sel_o   (rd_sel),
    .conflict_o (conflict)
  );

  // Next state, init walk and array update.
  always_comb begin
    state_d       = state_q;
    init_ptr_d    = init_ptr_q;
    wr_conflict_d = 1'b0;
    mem_d         = mem_q;

    case (state_q)
      INIT: begin
        // One entry per cycle; user writes are ignored until the walk ends.
        mem_d[init_ptr_q[SRAM_INDEX-1:0]] = RESET_VALUE;
        init_ptr_d = init_ptr_q + SRAM_INIT_PTR_W'(1);
        if (init_ptr_q == LAST_PTR) begin
          state_d = READY;
        end
      end
      READY: begin
        wr_conflict_d = conflict;
        // Ascending order: the highest-numbered port lands last and wins.
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_vld[w]) begin
            mem_d[addr_wr_i[w*SRAM_INDEX +: SRAM_INDEX]] = data_wr_i[w*SRAM_WIDTH +: SRAM_WIDTH];
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= INIT;
      init_ptr_q    <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Contents survive reset; only the init walk rewrites them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  // Combinational read ports.
  logic [SRAM_INDEX-1:0] rd_addr;
  logic [WSEL_W-1:0]     rd_win;

  always_comb begin
    data_rd_o = '0;
    rd_addr   = '0;
    rd_win    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr = addr_rd_i[p*SRAM_INDEX +: SRAM_INDEX];
      rd_win  = rd_sel[p*WSEL_W +: WSEL_W];
      if (state_q != READY) begin
        data_rd_o[p*SRAM_WIDTH +: SRAM_WIDTH] = RESET_VALUE;
      end else if ({1'b0, rd_addr} >= DEPTH_LIM) begin
        data_rd_o[p*SRAM_WIDTH +: SRAM_WIDTH] = '0;
      end else if (BYPASS_EN && rd_hit[p]) begin
        data_rd_o[p*SRAM_WIDTH +: SRAM_WIDTH] = data_wr_i[rd_win*SRAM_WIDTH +: SRAM_WIDTH];
      end else begin
        data_rd_o[p*SRAM_WIDTH +: SRAM_WIDTH] = mem_q[rd_addr];
      end
    end
  end

  assign ready_o       = (state_q == READY);
  assign wr_conflict_o = wr_conflict_q;

endmodule
`default_nettype wire
